serial_word_capture: RTL and testbench

//   Downstream stage of the Moore sequence-detector path. Consumes SerOut/SerOutValid,

---
 rtl/sercap_pkg.sv | 18 +
 rtl/serial_word_capture_bin2bcd.sv | 62 ++++++
 rtl/serial_word_capture.sv | 125 ++++++++++++
 tb/tb_serial_word_capture.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sercap_pkg.sv
// Shared types and helpers for serial_word_capture and its BCD converter.
package sercap_pkg;
  localparam int SERCAP_DATA_W     = 10;
  localparam int SERCAP_BCD_DIGITS = 4;
  localparam int BCD_W             = 4 * SERCAP_BCD_DIGITS;
  localparam int LEN_W             = 4;

  typedef enum logic [1:0] {IDLE, SHIFT, CONVERT, DONE} sercap_state_t;

  // Double-dabble correction: any digit of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_W / 4; i++)
      if (v[4*i +: 4] >= 4'd5) r[4*i +: 4] = v[4*i +: 4] + 4'd3;
    return r;
  endfunction
endpackage

// File: rtl/serial_word_capture_bin2bcd.sv
// Sequential double-dabble: one bit per clock, DATA_W clocks after start.
module bin2bcd_seq
  import sercap_pkg::*;
#(
  parameter int DATA_W     = SERCAP_DATA_W,
  parameter int BCD_DIGITS = SERCAP_BCD_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);
  localparam int IT_W = $clog2(DATA_W);
  localparam int W    = 4 * BCD_DIGITS;

  logic [DATA_W-1:0] bin_q, bin_d;
  logic [W-1:0]      acc_q, acc_d, acc_fix;
  logic [IT_W-1:0]   it_q, it_d;
  logic              run_q, run_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0;
      acc_q <= '0;
      it_q  <= '0;
      run_q <= 1'b0;
    end else begin
      bin_q <= bin_d;
      acc_q <= acc_d;
      it_q  <= it_d;
      run_q <= run_d;
    end
  end

  always_comb begin
    bin_d   = bin_q;
    acc_d   = acc_q;
    it_d    = it_q;
    run_d   = run_q;
    acc_fix = add3_digits(acc_q);
    if (start) begin
      bin_d = bin;
      acc_d = '0;
      it_d  = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = {acc_fix[W-2:0], bin_q[DATA_W-1]};
      bin_d = bin_q << 1;
      it_d  = it_q + 1'b1;
      if (it_q == IT_W'(DATA_W - 1)) begin
        run_d = 1'b0;
        it_d  = '0;
      end
    end
  end

  // High during the final iteration; acc_q holds the result on the next cycle.
  assign done = run_q && (it_q == IT_W'(DATA_W - 1));
  assign bcd  = acc_q;
endmodule

// File: rtl/serial_word_capture.sv
// Packs clk_EN-stepped serial bits into a word, then converts it to packed BCD.
// Optional sticky overflow output enabled by defining SERCAP_OVF_FLAG_EN.
module serial_word_capture
  import sercap_pkg::*;
#(
  parameter int DATA_W     = SERCAP_DATA_W,
  parameter int BCD_DIGITS = SERCAP_BCD_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_EN,
  input  logic                    ser_valid,
  input  logic                    ser_in,
  output logic [DATA_W-1:0]       word_out,
  output logic [3:0]              word_len,
  output logic                    word_ready,
  output logic                    busy,
  output logic [4*BCD_DIGITS-1:0] bcd
`ifdef SERCAP_OVF_FLAG_EN
  ,
  output logic                    ovf
`endif
);
  sercap_state_t           state_q, state_d;
  logic [DATA_W-1:0]       shreg_q, shreg_d, word_q, word_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d, len_q, len_d;
  logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, conv_bcd;
  logic                    wr_q, wr_d, start, conv_done;
`ifdef SERCAP_OVF_FLAG_EN
  logic                    ovf_q, ovf_d;
`endif

  bin2bcd_seq #(.DATA_W(DATA_W), .BCD_DIGITS(BCD_DIGITS)) u_bin2bcd (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .bin  (shreg_q),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      len_q   <= '0;
      bcd_q   <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      len_q   <= len_d;
      bcd_q   <= bcd_d;
      wr_q    <= wr_d;
    end
  end

`ifdef SERCAP_OVF_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  always_comb begin
    ovf_d = ovf_q;
    if (state_q == IDLE && clk_EN && ser_valid)
      ovf_d = 1'b0;
    else if (state_q == SHIFT && clk_EN && ser_valid && cnt_q == LEN_W'(DATA_W))
      ovf_d = 1'b1;
    else if ((state_q == CONVERT || state_q == DONE) && clk_EN && ser_valid)
      ovf_d = 1'b1;
  end

  assign ovf = ovf_q;
`endif

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    len_d   = len_q;
    bcd_d   = bcd_q;
    wr_d    = 1'b0;
    start   = 1'b0;
    case (state_q)
      IDLE: if (clk_EN && ser_valid) begin
        shreg_d = {{(DATA_W-1){1'b0}}, ser_in};
        cnt_d   = LEN_W'(1);
        state_d = SHIFT;
      end
      SHIFT: if (clk_EN) begin
        if (ser_valid) begin
          // Bits past DATA_W are dropped; the word keeps its first DATA_W bits.
          if (cnt_q < LEN_W'(DATA_W)) begin
            shreg_d = {shreg_q[DATA_W-2:0], ser_in};
            cnt_d   = cnt_q + 1'b1;
          end
        end else begin
          word_d  = shreg_q;
          len_d   = cnt_q;
          start   = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: if (conv_done) state_d = DONE;
      DONE: begin
        bcd_d   = conv_bcd;
        wr_d    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign word_out   = word_q;
  assign word_len   = len_q;
  assign bcd        = bcd_q;
  assign word_ready = wr_q;
  assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_serial_word_capture.sv
// Randomized scoreboard bench for serial_word_capture (honours SERCAP_OVF_FLAG_EN).
module tb_serial_word_capture;
  localparam int DATA_W = 10;

  typedef struct {
    int unsigned val;
    int unsigned len;
    int unsigned bcd;
    bit          ovf;
    int          end_cyc;
  } exp_t;

  logic              clk = 0, rst = 1, clk_EN = 0, ser_valid = 0, ser_in = 0;
  logic [DATA_W-1:0] word_out;
  logic [3:0]        word_len;
  logic              word_ready, busy, wr_prev = 0;
  logic [15:0]       bcd;
`ifdef SERCAP_OVF_FLAG_EN
  logic              ovf;
`endif

  int   tests = 0, fails = 0, cyc = 0;
  exp_t sb[$];

  serial_word_capture dut (
    .clk(clk), .rst(rst), .clk_EN(clk_EN), .ser_valid(ser_valid), .ser_in(ser_in),
    .word_out(word_out), .word_len(word_len), .word_ready(word_ready), .busy(busy),
    .bcd(bcd)
`ifdef SERCAP_OVF_FLAG_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned to_bcd(input int unsigned v);
    int unsigned b = 0;
    for (int d = 0; d < 4; d++) begin
      b |= (v % 10) << (4 * d);
      v /= 10;
    end
    return b;
  endfunction

  // Called at #1 after a posedge; returns at #1 after the sampling edge.
  task automatic step(input logic v, input logic b);
    clk_EN = 1; ser_valid = v; ser_in = b;
    @(posedge clk); #1;
    clk_EN = 0; ser_valid = 1'($urandom); ser_in = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      ser_valid = 1'($urandom); ser_in = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  // pattern[i] is the i-th arriving bit; stray issues a step while converting.
  task automatic frame(input int n, input logic [15:0] pattern, input bit stray);
    exp_t e;
    e.val = 0;
    for (int i = 0; i < n && i < DATA_W; i++) e.val = e.val * 2 + pattern[i];
    e.len = (n > DATA_W) ? DATA_W : n;
    e.bcd = to_bcd(e.val);
    e.ovf = (n > DATA_W) || stray;
    for (int i = 0; i < n; i++) begin
      idle($urandom_range(0, 2));
      step(1'b1, pattern[i]);
    end
    step(1'b0, 1'b0);
    e.end_cyc = cyc;
    sb.push_back(e);
    if (stray) begin
      idle(3);
      step(1'b1, 1'b1);
      idle(DATA_W + 2);
    end else begin
      idle(DATA_W + 3);
    end
  endtask

  // Monitor: every word_ready pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      wr_prev <= 1'b0;
    end else begin
      if (word_ready) begin
        chk("word_ready_one_cycle", 32'(wr_prev), 32'd0);
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_word_ready: got pulse, expected none (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("word_out", 32'(word_out), e.val);
          chk("word_len", 32'(word_len), e.len);
          chk("bcd", 32'(bcd), e.bcd);
          chk("latency", 32'(cyc - e.end_cyc), 32'(DATA_W + 1));
`ifdef SERCAP_OVF_FLAG_EN
          chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
        end
      end
      wr_prev <= word_ready;
    end
  end

  initial begin
    int waited;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_word_out", 32'(word_out), 0);
    chk("reset_word_len", 32'(word_len), 0);
    chk("reset_bcd", 32'(bcd), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_word_ready", 32'(word_ready), 0);
    rst = 0;
    idle(2);

    frame(3, 16'h0005, 1'b0);    // 1,0,1 -> 5
    frame(10, 16'h03FF, 1'b0);   // 1023
    frame(12, 16'h03FF, 1'b0);   // two extra zeros dropped

    // clk_EN low: ser_valid activity must not start a frame
    repeat (20) begin
      ser_valid = ~ser_valid; ser_in = 1'($urandom);
      @(posedge clk); #1;
      chk("no_step_busy", 32'(busy), 0);
    end

    frame(3, 16'h0003, 1'b1);    // stray step during convert
    frame(4, 16'h000D, 1'b0);    // ovf must have been cleared at frame start

    // Reset in the middle of conversion: no result, outputs cleared at once
    step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b1, 1'b1); step(1'b0, 1'b0);
    idle(4);
    chk("pre_rst_busy", 32'(busy), 1);
    rst = 1; #1;
    chk("rst_word_out", 32'(word_out), 0);
    chk("rst_word_len", 32'(word_len), 0);
    chk("rst_bcd", 32'(bcd), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk); #1;
    rst = 0;
    idle(DATA_W + 3);
    frame(2, 16'h0003, 1'b0);    // 1,1 -> bcd 3

    repeat (40) frame($urandom_range(1, 13), 16'($urandom), ($urandom_range(0, 4) == 0));

    waited = 0;
    while (sb.size() != 0 && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
